core_inst_sequencer: RTL and testbench
======================================

CORE_INST_SEQUENCER -- requirements
Module: core_inst_sequencer

Interface
REQ-001 SHALL have parameter row, default 2, meaning PE rows, matching core.
REQ-002 SHALL have parameter col, default 2, meaning PE columns, matching core.
REQ-003 SHALL have parameter nij, default 16, meaning activation vectors per kernel position.
REQ-004 SHALL have parameter kij, default 9, meaning kernel positions per run.
REQ-005 SHALL have parameter addr_bw, default 11, meaning SRAM address width.
REQ-006 SHALL have port clk  in  1  clock; one clock.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  in  1  one-cycle run request.
REQ-009 SHALL have ports w_base, a_base, o_base  in  addr_bw each  xmem weight base, xmem activation base and pmem output base.
REQ-010 SHALL have ports mode_in  in  1, sel_in  in  1, tile_in  in  2  run configuration.
REQ-011 SHALL have port ofifo_valid  in  1  core output-FIFO data valid.
REQ-012 SHALL have port inst  out  34  core instruction word.
REQ-013 SHALL have ports mode  out  1, sel  out  1, tile  out  2  registered configuration to core.
REQ-014 SHALL have ports busy  out  1  and done  out  1  run status; done is a one-cycle pulse.

Function
REQ-015 inst field map SHALL be: [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem; [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem; [6] ofifo_rd; [5:4] held 0; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
REQ-016 The idle word SHALL be 34'h1_800C_0000: both CENs and both WENs high, all other bits 0.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 FSM states SHALL be IDLE, WRD, WLD, ARD, EXE, DRN, NXT and DONE; a counter k (0..kij-1) and a counter n SHALL be kept.
REQ-019 In IDLE, on start: latch bases, mode_in, sel_in and tile_in; clear k; go to WRD; assert busy on the next cycle.
REQ-020 start SHALL be ignored while busy.
REQ-021 WRD SHALL last col+1 cycles: cycles 0..col-1 read xmem at A_xmem = w_base + k*col + c, with CEN_xmem=0 and WEN_xmem=1.
REQ-022 In WRD, l0_wr SHALL be asserted in cycles 1..col, a one-word lag behind each read address.
REQ-023 WLD SHALL last row+col cycles with load=1 and l0_rd=1.
REQ-024 ARD SHALL last nij+1 cycles: reads at a_base + n for n = 0..nij-1, with l0_wr lagging by one word.
REQ-025 EXE SHALL last nij cycles with execute=1 and l0_rd=1.
REQ-026 In DRN, each cycle with ofifo_valid=1 SHALL issue ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = o_base + n, acc = (k!=0), and increment n.
REQ-027 In DRN, a cycle with ofifo_valid=0 SHALL emit the idle word and hold n (stall without limit).
REQ-028 DRN SHALL exit after nij writes to NXT; in NXT, k = kij-1 SHALL go to DONE, otherwise k SHALL increment and go to WRD.
REQ-029 DONE SHALL pulse done for one cycle, deassert busy and return to IDLE.
REQ-030 In DONE, sel SHALL toggle for the next run (ping-pong bank) unless overwritten by the next start.
REQ-031 Address sums SHALL wrap modulo 2^addr_bw.
REQ-032 n SHALL clear on every state entry.
REQ-033 Every cycle not specified above SHALL emit the idle word.
REQ-034 A start coinciding with the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-035 While reset_n=0, regardless of clk: state=IDLE, inst=idle word, busy=0, done=0, mode=0, sel=0, tile=0, k=0, n=0.
REQ-036 Reset mid-run SHALL abandon the run with no done pulse; the first post-reset start SHALL begin a fresh run from k=0.

Structure
REQ-037 Shared package core_pkg SHALL hold: inst bit-position constants, the idle-word constant, the FSM state enum and the addr_bw default.
REQ-038 A single sub-module, seq_addr_gen (base + offset, modulo-wrap adder with counter), is natural and SHALL be used for both xmem and pmem addressing.

Verification
REQ-039 start, kij=1, w_base=0x010, ofifo_valid=1 -> A_xmem sequence 0x010, 0x011, then WLD for 4 cycles; DRN writes A_pmem o_base..o_base+15 with acc=0; done occurs exactly once.
REQ-040 Full run with kij=9 -> k=1..8 drains all have acc=1; weight addresses for k=8 are w_base+16 and w_base+17.
REQ-041 In DRN, hold ofifo_valid low for 5 cycles at n=7 -> 5 idle words are emitted, the next write is at o_base+7, and there are no duplicate or skipped addresses.
REQ-042 w_base=0x7FF, col=2 -> second read wraps to 0x000.
REQ-043 Pulse reset_n low during EXE -> idle word and busy=0 immediately (asynchronous), no done pulse; a new start runs from k=0.
REQ-044 start asserted while busy, and in the DONE cycle -> ignored; sel toggles after each completed run.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: instruction word
// bit positions, the idle word and the sequencer state encoding.
package core_pkg;

   localparam int addr_bw_def = 11;

   localparam int b_acc      = 33;
   localparam int b_cen_p    = 32;
   localparam int b_wen_p    = 31;
   localparam int b_ap_hi    = 30;
   localparam int b_ap_lo    = 20;
   localparam int b_cen_x    = 19;
   localparam int b_wen_x    = 18;
   localparam int b_ax_hi    = 17;
   localparam int b_ax_lo    = 7;
   localparam int b_ofifo_rd = 6;
   localparam int b_l0_rd    = 3;
   localparam int b_l0_wr    = 2;
   localparam int b_execute  = 1;
   localparam int b_load     = 0;

   // Both memories deselected and write-disabled, no core activity.
   localparam logic [33:0] idle_word = 34'h1_800C_0000;

   typedef enum logic [2:0] {
      IDLE, WRD, WLD, ARD, EXE, DRN, NXT, DONE
   } state_t;

endpackage

// File: rtl/core_inst_sequencer_if.sv
// Run request, configuration, output-FIFO status and instruction/status
// outputs between the controlling agent (master) and the sequencer (slave).
interface core_inst_sequencer_if
   import core_pkg::*;
#(
   parameter int addr_bw = addr_bw_def
);
   logic               start;
   logic [addr_bw-1:0] w_base;
   logic [addr_bw-1:0] a_base;
   logic [addr_bw-1:0] o_base;
   logic               mode_in;
   logic               sel_in;
   logic [1:0]         tile_in;
   logic               ofifo_valid;
   logic [33:0]        inst;
   logic               mode;
   logic               sel;
   logic [1:0]         tile;
   logic               busy;
   logic               done;

   modport master (
      output start, w_base, a_base, o_base, mode_in, sel_in, tile_in, ofifo_valid,
      input  inst, mode, sel, tile, busy, done
   );

   modport slave (
      input  start, w_base, a_base, o_base, mode_in, sel_in, tile_in, ofifo_valid,
      output inst, mode, sel, tile, busy, done
   );

endinterface

// File: rtl/seq_addr_gen.sv
// Base + running offset address generator; the sum wraps at addr_bw bits.
module seq_addr_gen #(
   parameter int addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               inc,
   input  logic [addr_bw-1:0] base,
   output logic [addr_bw-1:0] addr
);
   logic [addr_bw-1:0] off;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         off <= '0;
      else if (clr)
         off <= '0;
      else if (inc)
         off <= off + addr_bw'(1);
   end

   assign addr = base + off;

endmodule

// File: rtl/core_inst_sequencer.sv
// Steps the core through weight load, activation stream, execute and output
// drain for every kernel position, emitting one registered instruction word per cycle.
//
// state | meaning
// IDLE  | waiting for start
// WRD   | read col weight words from xmem into L0
// WLD   | shift weights from L0 into the PE array
// ARD   | read nij activation words from xmem into L0
// EXE   | stream activations through the array
// DRN   | move nij results from the output FIFO to pmem, stalling on empty FIFO
// NXT   | advance kernel position or finish
// DONE  | done pulse visible, start ignored
module core_inst_sequencer
   import core_pkg::*;
#(
   parameter int row     = 2,
   parameter int col     = 2,
   parameter int nij     = 16,
   parameter int kij     = 9,
   parameter int addr_bw = addr_bw_def
) (
   input logic                  clk,
   input logic                  reset_n,
   core_inst_sequencer_if.slave bus
);
   state_t             state;
   logic [15:0]        n;
   logic [15:0]        k;
   logic [addr_bw-1:0] w_base_q, a_base_q, o_base_q;
   logic [addr_bw-1:0] w_addr, a_addr, o_addr;
   logic [33:0]        inst_q;
   logic               busy_q, done_q, mode_q, sel_q;
   logic [1:0]         tile_q;
   logic               w_clr, w_inc, a_clr, a_inc, o_clr, o_inc;

   // The weight offset is never cleared between kernel positions, so it
   // naturally runs through k*col + c.
   assign w_clr = (state == IDLE) && bus.start;
   assign w_inc = (state == WRD) && (n < 16'(col));
   assign a_clr = (state == WLD);
   assign a_inc = (state == ARD) && (n < 16'(nij));
   assign o_clr = (state == EXE);
   assign o_inc = (state == DRN) && bus.ofifo_valid;

   seq_addr_gen #(.addr_bw(addr_bw)) u_w_gen (
      .clk(clk), .reset_n(reset_n), .clr(w_clr), .inc(w_inc), .base(w_base_q), .addr(w_addr)
   );
   seq_addr_gen #(.addr_bw(addr_bw)) u_a_gen (
      .clk(clk), .reset_n(reset_n), .clr(a_clr), .inc(a_inc), .base(a_base_q), .addr(a_addr)
   );
   seq_addr_gen #(.addr_bw(addr_bw)) u_o_gen (
      .clk(clk), .reset_n(reset_n), .clr(o_clr), .inc(o_inc), .base(o_base_q), .addr(o_addr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         n        <= '0;
         k        <= '0;
         w_base_q <= '0;
         a_base_q <= '0;
         o_base_q <= '0;
         inst_q   <= idle_word;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mode_q   <= 1'b0;
         sel_q    <= 1'b0;
         tile_q   <= '0;
      end else begin
         inst_q <= idle_word;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  w_base_q <= bus.w_base;
                  a_base_q <= bus.a_base;
                  o_base_q <= bus.o_base;
                  mode_q   <= bus.mode_in;
                  sel_q    <= bus.sel_in;
                  tile_q   <= bus.tile_in;
                  k        <= '0;
                  n        <= '0;
                  busy_q   <= 1'b1;
                  state    <= WRD;
               end
            end
            WRD: begin
               if (n < 16'(col)) begin
                  inst_q[b_cen_x]         <= 1'b0;
                  inst_q[b_ax_hi:b_ax_lo] <= w_addr;
               end
               if (n != 16'd0)
                  inst_q[b_l0_wr] <= 1'b1;
               if (n == 16'(col)) begin
                  n     <= '0;
                  state <= WLD;
               end else
                  n <= n + 16'd1;
            end
            WLD: begin
               inst_q[b_load]  <= 1'b1;
               inst_q[b_l0_rd] <= 1'b1;
               if (n == 16'(row + col - 1)) begin
                  n     <= '0;
                  state <= ARD;
               end else
                  n <= n + 16'd1;
            end
            ARD: begin
               if (n < 16'(nij)) begin
                  inst_q[b_cen_x]         <= 1'b0;
                  inst_q[b_ax_hi:b_ax_lo] <= a_addr;
               end
               if (n != 16'd0)
                  inst_q[b_l0_wr] <= 1'b1;
               if (n == 16'(nij)) begin
                  n     <= '0;
                  state <= EXE;
               end else
                  n <= n + 16'd1;
            end
            EXE: begin
               inst_q[b_execute] <= 1'b1;
               inst_q[b_l0_rd]   <= 1'b1;
               if (n == 16'(nij - 1)) begin
                  n     <= '0;
                  state <= DRN;
               end else
                  n <= n + 16'd1;
            end
            DRN: begin
               // An empty FIFO leaves the idle word and n untouched.
               if (bus.ofifo_valid) begin
                  inst_q[b_ofifo_rd]      <= 1'b1;
                  inst_q[b_cen_p]         <= 1'b0;
                  inst_q[b_wen_p]         <= 1'b0;
                  inst_q[b_ap_hi:b_ap_lo] <= o_addr;
                  inst_q[b_acc]           <= (k != 16'd0);
                  if (n == 16'(nij - 1)) begin
                     n     <= '0;
                     state <= NXT;
                  end else
                     n <= n + 16'd1;
               end
            end
            NXT: begin
               n <= '0;
               if (k == 16'(kij - 1)) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  sel_q  <= ~sel_q;
                  state  <= DONE;
               end else begin
                  k     <= k + 16'd1;
                  state <= WRD;
               end
            end
            DONE: begin
               n     <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.inst = inst_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.mode = mode_q;
   assign bus.sel  = sel_q;
   assign bus.tile = tile_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: full runs, drain stall, address wrap,
// mid-run reset and start filtering around DONE.
module tb_core_inst_sequencer;
   import core_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   core_inst_sequencer_if #(.addr_bw(11)) bus ();

   core_inst_sequencer #(
      .row(2), .col(2), .nij(16), .kij(9), .addr_bw(11)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [10:0] xr_q[$];
   int          xr_cyc[$];
   logic [10:0] pw_q[$];
   bit          pacc_q[$];
   int          pw_cyc[$];
   int          ld_cyc[$];
   int          l0wr_cyc[$];
   int          ex_cnt, ord_cnt, done_cnt, acc_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      xr_q.delete(); xr_cyc.delete(); pw_q.delete(); pacc_q.delete();
      pw_cyc.delete(); ld_cyc.delete(); l0wr_cyc.delete();
      ex_cnt = 0; ord_cnt = 0; done_cnt = 0; acc_cnt = 0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         cyc++;
         if (!bus.inst[b_cen_x]) begin
            xr_q.push_back(bus.inst[b_ax_hi:b_ax_lo]);
            xr_cyc.push_back(cyc);
         end
         if (!bus.inst[b_cen_p]) begin
            pw_q.push_back(bus.inst[b_ap_hi:b_ap_lo]);
            pacc_q.push_back(bus.inst[b_acc]);
            pw_cyc.push_back(cyc);
            if (bus.inst[b_acc]) acc_cnt++;
         end
         if (bus.inst[b_load])     ld_cyc.push_back(cyc);
         if (bus.inst[b_l0_wr])    l0wr_cyc.push_back(cyc);
         if (bus.inst[b_execute])  ex_cnt++;
         if (bus.inst[b_ofifo_rd]) ord_cnt++;
         if (bus.done)             done_cnt++;
      end
   end

   initial begin
      bit ok;
      int errs;
      int k0_ld;

      bus.start = 1'b0; bus.w_base = '0; bus.a_base = '0; bus.o_base = '0;
      bus.mode_in = 1'b0; bus.sel_in = 1'b0; bus.tile_in = '0; bus.ofifo_valid = 1'b1;
      clear_log();

      repeat (2) @(negedge clk); #1;
      chk("rst_inst", bus.inst, 34'h1_800C_0000);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mode", bus.mode, 0);
      chk("rst_sel",  bus.sel, 0);
      chk("rst_tile", bus.tile, 0);
      reset_n = 1'b1;
      @(negedge clk); #1;

      // run 1: full kij=9 run with a 5-cycle FIFO stall and a start while busy
      clear_log();
      bus.w_base = 11'h010; bus.a_base = 11'h100; bus.o_base = 11'h200;
      bus.mode_in = 1'b1; bus.sel_in = 1'b0; bus.tile_in = 2'd2;
      pulse_start();
      chk("r1_busy_after_start", bus.busy, 1);
      fork
         begin
            for (int i = 0; i < 500; i++) begin
               @(negedge clk); #1;
               if (pw_q.size() == 7) break;
            end
            bus.ofifo_valid = 1'b0;
            repeat (5) @(negedge clk);
            bus.ofifo_valid = 1'b1;
         end
         begin
            repeat (10) @(negedge clk); #1;
            bus.mode_in = 1'b0; bus.sel_in = 1'b1; bus.tile_in = 2'd3; bus.w_base = 11'h3AA;
            pulse_start();
         end
      join
      wait_done(2000, ok);
      chk("r1_done_seen", ok, 1);
      bus.start = 1'b1;
      chk("r1_xr_cnt", xr_q.size(), 162);
      chk("r1_w_k0_0", xr_q[0], 11'h010);
      chk("r1_w_k0_1", xr_q[1], 11'h011);
      chk("r1_a_first", xr_q[2], 11'h100);
      chk("r1_a_last", xr_q[17], 11'h10F);
      chk("r1_w_k8_0", xr_q[144], 11'h020);
      chk("r1_w_k8_1", xr_q[145], 11'h021);
      chk("r1_l0wr_cnt", l0wr_cyc.size(), 162);
      chk("r1_l0wr_lag", l0wr_cyc[0] - xr_cyc[0], 1);
      k0_ld = 0;
      foreach (ld_cyc[i]) if (ld_cyc[i] < xr_cyc[2]) k0_ld++;
      chk("r1_wld_k0_len", k0_ld, 4);
      chk("r1_wld_k0_start", ld_cyc[0] - xr_cyc[0], 3);
      chk("r1_ld_cnt", ld_cyc.size(), 36);
      chk("r1_ex_cnt", ex_cnt, 144);
      chk("r1_pw_cnt", pw_q.size(), 144);
      chk("r1_ord_cnt", ord_cnt, 144);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (int'(pw_q[i]) != 'h200 + i) errs++;
         if (pacc_q[i]) errs++;
      end
      chk("r1_drn_k0_seq_acc0", errs, 0);
      chk("r1_stall_gap", pw_cyc[7] - pw_cyc[6], 6);
      chk("r1_k1_first_wr", pw_q[16], 11'h200);
      chk("r1_k8_last_wr", pw_q[143], 11'h20F);
      chk("r1_acc_cnt", acc_cnt, 128);
      chk("r1_done_cnt", done_cnt, 1);
      chk("r1_mode_kept", bus.mode, 1);
      chk("r1_tile_kept", bus.tile, 2);
      chk("r1_sel_toggled", bus.sel, 1);
      @(negedge clk); #1;
      bus.start = 1'b0;
      chk("r1_done_cycle_start_ignored", bus.busy, 0);
      repeat (3) @(negedge clk); #1;
      chk("r1_idle_after_done_busy", bus.busy, 0);
      chk("r1_done_single", done_cnt, 1);

      // run 2: weight address wrap, then asynchronous reset during EXE
      clear_log();
      bus.w_base = 11'h7FF; bus.a_base = 11'h000; bus.o_base = 11'h000;
      bus.mode_in = 1'b1; bus.sel_in = 1'b1; bus.tile_in = 2'd3;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (bus.inst[b_execute]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("r2_exe_seen", ok, 1);
      chk("r2_wrap_0", xr_q[0], 11'h7FF);
      chk("r2_wrap_1", xr_q[1], 11'h000);
      #2 reset_n = 1'b0;
      #1;
      chk("r2_async_inst", bus.inst, 34'h1_800C_0000);
      chk("r2_async_busy", bus.busy, 0);
      @(negedge clk); #1;
      chk("r2_rst_sel", bus.sel, 0);
      chk("r2_rst_mode", bus.mode, 0);
      chk("r2_rst_tile", bus.tile, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk); #1;
      chk("r2_no_done", done_cnt, 0);
      chk("r2_busy_after_rst", bus.busy, 0);

      // run 3: fresh run after reset, pmem wrap, start held across DONE into IDLE
      clear_log();
      bus.w_base = 11'h123; bus.a_base = 11'h050; bus.o_base = 11'h7F8;
      bus.mode_in = 1'b0; bus.sel_in = 1'b1; bus.tile_in = 2'd1;
      pulse_start();
      wait_done(2000, ok);
      chk("r3_done_seen", ok, 1);
      bus.start = 1'b1;
      chk("r3_w_k0_0", xr_q[0], 11'h123);
      chk("r3_w_k0_1", xr_q[1], 11'h124);
      chk("r3_pw_7", pw_q[7], 11'h7FF);
      chk("r3_pw_wrap", pw_q[8], 11'h000);
      chk("r3_acc_k0", pacc_q[0], 0);
      chk("r3_acc_k1", pacc_q[16], 1);
      chk("r3_sel_toggled", bus.sel, 0);
      chk("r3_done_cnt", done_cnt, 1);
      @(negedge clk); #1;
      chk("r3_start_in_done_ignored", bus.busy, 0);
      @(negedge clk); #1;
      bus.start = 1'b0;
      chk("r3_start_in_idle_taken", bus.busy, 1);
      chk("r3_sel_relatched", bus.sel, 1);

      reset_n = 1'b0;
      #20;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
